// File: rtl/uart_tx_pkg.sv
// uart_tx_pkg: shared constants for the UART transmit peripheral.
// Holds register offsets, STATUS bit positions, the STATUS word layout,
// the transmitter FSM state encoding and the reset baud divisor.
package uart_tx_pkg;

    localparam int unsigned DATA_W      = 32;
    localparam int unsigned ADDR_W      = 4;
    localparam int unsigned MASK_W      = 4;
    localparam int unsigned DIV_W       = 16;
    localparam int unsigned BYTE_W      = 8;
    localparam int unsigned CNT_FIELD_W = 5;

    // Byte offsets of the registers; only addr[3:2] selects a register.
    localparam logic [ADDR_W-1:0] OFF_TXDATA = 4'h0;
    localparam logic [ADDR_W-1:0] OFF_STATUS = 4'h4;
    localparam logic [ADDR_W-1:0] OFF_DIV    = 4'h8;
    localparam logic [ADDR_W-1:0] OFF_CTRL   = 4'hC;

    localparam logic [1:0] IDX_TXDATA = OFF_TXDATA[3:2];
    localparam logic [1:0] IDX_STATUS = OFF_STATUS[3:2];
    localparam logic [1:0] IDX_DIV    = OFF_DIV[3:2];
    localparam logic [1:0] IDX_CTRL   = OFF_CTRL[3:2];

    // STATUS bit positions.
    localparam int unsigned STAT_FULL   = 0;
    localparam int unsigned STAT_EMPTY  = 1;
    localparam int unsigned STAT_BUSY   = 2;
    localparam int unsigned STAT_OVF    = 3;
    localparam int unsigned STAT_CNT_LO = 4;
    localparam int unsigned STAT_CNT_HI = 8;

    // CTRL bit positions.
    localparam int unsigned CTRL_TXEN  = 0;
    localparam int unsigned CTRL_IRQEN = 1;

    localparam logic [DIV_W-1:0] UART_DEFAULT_DIV = 16'd868;

    // STATUS word as seen on the read bus (LSB = full).
    typedef struct packed {
        logic [DATA_W-CNT_FIELD_W-5:0] rsvd;
        logic [CNT_FIELD_W-1:0]        count;
        logic                          ovf;
        logic                          busy;
        logic                          empty;
        logic                          full;
    } status_t;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_e;

    // Register index from a byte offset.
    function automatic logic [1:0] reg_index(input logic [ADDR_W-1:0] addr);
        return addr[3:2];
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: synchronous FIFO holding bytes waiting for transmission.
// Ports:
//   clk_i, reset_i  clock, asynchronous active-low reset
//   push, wr_data   enqueue (ignored when full)
//   pop             dequeue (ignored when empty)
//   rd_data_c       head entry, combinational from the read pointer
//   full, empty     registered occupancy flags
//   count           registered number of stored entries
module uart_tx_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 8
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wr_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rd_data_c,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count_d;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Next occupancy.
    always_comb begin
        count_d = count;
        if (do_push && !do_pop) begin
            count_d = count + CNT_W'(1);
        end else if (do_pop && !do_push) begin
            count_d = count - CNT_W'(1);
        end
    end

    // Pointers, count and flags.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count_d;
            full  <= (count_d == CNT_W'(DEPTH));
            empty <= (count_d == '0);
        end
    end

    // Storage; contents need no reset since empty gates every read.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    assign rd_data_c = mem[rd_ptr];

endmodule

// File: rtl/uart_tx_periph.sv
// uart_tx_periph: memory-mapped 8N1 UART transmitter with a TX FIFO.
// Optional feature macro: UART_TX_IRQ_EN (TX-empty interrupt and CTRL.IRQEN);
// without it irq_o is tied low and CTRL bit1 reads 0.
// Ports:
//   clk_i, reset_i  clock, asynchronous active-low reset
//   csb_i, wen_i    active-low chip select / write enable (sampled on clk_i)
//   addr_i          byte offset; bits [1:0] ignored
//   data_i, wmask_i write data and per-byte write mask
//   data_o          combinational read data (0 unless a read is selected)
//   tx_o            serial output, idle high
//   irq_o           TX-empty interrupt
module uart_tx_periph
    import uart_tx_pkg::*;
#(
    parameter int unsigned       FIFO_DEPTH  = 8,
    parameter logic [DIV_W-1:0]  DEFAULT_DIV = UART_DEFAULT_DIV
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic                 csb_i,
    input  logic                 wen_i,
    input  logic [ADDR_W-1:0]    addr_i,
    input  logic [DATA_W-1:0]    data_i,
    input  logic [MASK_W-1:0]    wmask_i,
    output logic [DATA_W-1:0]    data_o,
    output logic                 tx_o,
    output logic                 irq_o
);

    localparam int unsigned FIFO_CNT_W = $clog2(FIFO_DEPTH) + 1;

    // Bus decode.
    logic       wr_c;
    logic       rd_c;
    logic [1:0] reg_sel;
    logic       push_c;

    assign wr_c    = !csb_i && !wen_i;
    assign rd_c    = !csb_i && wen_i;
    assign reg_sel = reg_index(addr_i);
    assign push_c  = wr_c && (reg_sel == IDX_TXDATA) && wmask_i[0];

    // Control/status state.
    logic [DIV_W-1:0] div_q;
    logic             txen_q;
    logic             ovf_q;

    // FIFO interface.
    logic [BYTE_W-1:0]     fifo_rd_data;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [FIFO_CNT_W-1:0] fifo_count;
    logic                  fifo_pop;

    uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (BYTE_W)
    ) u_fifo (
        .clk_i     (clk_i),
        .reset_i   (reset_i),
        .push      (push_c),
        .wr_data   (data_i[BYTE_W-1:0]),
        .pop       (fifo_pop),
        .rd_data_c (fifo_rd_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // Transmitter state.
    tx_state_e         state_q,   state_d;
    logic [DIV_W-1:0]  clk_cnt_q, clk_cnt_d;
    logic [2:0]        bit_cnt_q, bit_cnt_d;
    logic [BYTE_W-1:0] shift_q,   shift_d;
    logic              tx_q,      tx_d;
    logic              busy;
    logic              start_ok;
    logic              bit_done;
    logic [DIV_W-1:0]  bit_reload;

    assign busy     = (state_q != TX_IDLE);
    assign start_ok = txen_q && !fifo_empty;
    assign bit_done = (clk_cnt_q == '0);
    // Down-counter reload sampled at each bit boundary, so a DIV write
    // mid-bit only affects the following bit. DIV=0 behaves as DIV=1.
    assign bit_reload = (div_q == '0) ? '0 : (div_q - DIV_W'(1));

    // Register writes and sticky overflow.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            div_q  <= DEFAULT_DIV;
            txen_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            if (push_c && fifo_full) begin
                ovf_q <= 1'b1;
            end else if (wr_c && (reg_sel == IDX_STATUS) && wmask_i[0] &&
                         data_i[STAT_OVF]) begin
                ovf_q <= 1'b0;
            end
            if (wr_c && (reg_sel == IDX_DIV)) begin
                if (wmask_i[0]) div_q[7:0]  <= data_i[7:0];
                if (wmask_i[1]) div_q[15:8] <= data_i[15:8];
            end
            if (wr_c && (reg_sel == IDX_CTRL) && wmask_i[0]) begin
                txen_q <= data_i[CTRL_TXEN];
            end
        end
    end

`ifdef UART_TX_IRQ_EN
    logic irqen_q;

    // Interrupt enable.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            irqen_q <= 1'b0;
        end else if (wr_c && (reg_sel == IDX_CTRL) && wmask_i[0]) begin
            irqen_q <= data_i[CTRL_IRQEN];
        end
    end

    assign irq_o = irqen_q & fifo_empty & ~busy;
`else
    logic irqen_q;
    assign irqen_q = 1'b0;
    assign irq_o   = 1'b0;
`endif

    // FSM state register and datapath registers.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q   <= TX_IDLE;
            clk_cnt_q <= '0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            tx_q      <= 1'b1;
        end else begin
            state_q   <= state_d;
            clk_cnt_q <= clk_cnt_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            tx_q      <= tx_d;
        end
    end

    // FSM next state, FIFO pop and serial output.
    always_comb begin
        state_d   = state_q;
        clk_cnt_d = clk_cnt_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        tx_d      = tx_q;
        fifo_pop  = 1'b0;
        case (state_q)
            TX_IDLE: begin
                tx_d = 1'b1;
                if (start_ok) begin
                    fifo_pop  = 1'b1;
                    state_d   = TX_START;
                    tx_d      = 1'b0;
                    shift_d   = fifo_rd_data;
                    bit_cnt_d = '0;
                    clk_cnt_d = bit_reload;
                end
            end
            TX_START: begin
                if (bit_done) begin
                    state_d   = TX_DATA;
                    tx_d      = shift_q[0];
                    shift_d   = shift_q >> 1;
                    clk_cnt_d = bit_reload;
                end else begin
                    clk_cnt_d = clk_cnt_q - DIV_W'(1);
                end
            end
            TX_DATA: begin
                if (bit_done) begin
                    clk_cnt_d = bit_reload;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = TX_STOP;
                        tx_d    = 1'b1;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'(1);
                        tx_d      = shift_q[0];
                        shift_d   = shift_q >> 1;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q - DIV_W'(1);
                end
            end
            TX_STOP: begin
                if (bit_done) begin
                    if (start_ok) begin
                        // Back-to-back frame: start bit follows the stop bit directly.
                        fifo_pop  = 1'b1;
                        state_d   = TX_START;
                        tx_d      = 1'b0;
                        shift_d   = fifo_rd_data;
                        bit_cnt_d = '0;
                        clk_cnt_d = bit_reload;
                    end else begin
                        state_d = TX_IDLE;
                        tx_d    = 1'b1;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q - DIV_W'(1);
                end
            end
            default: begin
                state_d = TX_IDLE;
                tx_d    = 1'b1;
            end
        endcase
    end

    assign tx_o = tx_q;

    // Read mux.
    status_t status_c;

    always_comb begin
        status_c       = '0;
        status_c.full  = fifo_full;
        status_c.empty = fifo_empty;
        status_c.busy  = busy;
        status_c.ovf   = ovf_q;
        status_c.count = CNT_FIELD_W'(fifo_count);
    end

    always_comb begin
        data_o = '0;
        if (rd_c) begin
            case (reg_sel)
                IDX_STATUS: data_o = status_c;
                IDX_DIV:    data_o = DATA_W'(div_q);
                IDX_CTRL:   data_o = DATA_W'({irqen_q, txen_q});
                default:    data_o = '0;
            endcase
        end
    end

    // Bus bits that carry no meaning for this block.
    logic unused_bits;
    assign unused_bits = ^{addr_i[1:0], data_i[31:16], wmask_i[3:2]};

endmodule

// File: tb/tb_uart_tx_periph.sv
// tb_uart_tx_periph: self-checking bench for uart_tx_periph.
// Register vectors from a table, then directed sequences for framing,
// overflow, back-to-back frames, divisor changes, TXEN clear and reset.
module tb_uart_tx_periph;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic        csb_i;
    logic        wen_i;
    logic [3:0]  addr_i;
    logic [31:0] data_i;
    logic [3:0]  wmask_i;
    logic [31:0] data_o;
    logic        tx_o;
    logic        irq_o;

    int tests = 0;
    int fails = 0;

    localparam logic [3:0] A_TX = 4'h0;
    localparam logic [3:0] A_ST = 4'h4;
    localparam logic [3:0] A_DV = 4'h8;
    localparam logic [3:0] A_CT = 4'hC;

`ifdef UART_TX_IRQ_EN
    localparam logic [31:0] CTRL_ALL = 32'h3;
    localparam logic [31:0] IRQ_EXP  = 32'h1;
`else
    localparam logic [31:0] CTRL_ALL = 32'h1;
    localparam logic [31:0] IRQ_EXP  = 32'h0;
`endif

    always #5 clk_i = ~clk_i;

    uart_tx_periph #(
        .FIFO_DEPTH  (8),
        .DEFAULT_DIV (16'd868)
    ) dut (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .csb_i   (csb_i),
        .wen_i   (wen_i),
        .addr_i  (addr_i),
        .data_i  (data_i),
        .wmask_i (wmask_i),
        .data_o  (data_o),
        .tx_o    (tx_o),
        .irq_o   (irq_o)
    );

    typedef struct {
        logic        wr;
        logic [3:0]  addr;
        logic [31:0] wdata;
        logic [3:0]  mask;
        logic [31:0] exp;
        string       name;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, got, exp, $time);
        end
    endtask

    // Called at a negedge; the write lands on the following posedge.
    task automatic bus_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] m);
        csb_i   = 1'b0;
        wen_i   = 1'b0;
        addr_i  = a;
        data_i  = d;
        wmask_i = m;
        @(negedge clk_i);
        csb_i = 1'b1;
        wen_i = 1'b1;
    endtask

    task automatic bus_read(input logic [3:0] a, output logic [31:0] d);
        csb_i  = 1'b0;
        wen_i  = 1'b1;
        addr_i = a;
        #1;
        d     = data_o;
        csb_i = 1'b1;
    endtask

    task automatic read_check(input string name, input logic [3:0] a, input logic [31:0] exp);
        logic [31:0] d;
        bus_read(a, d);
        check(name, d, exp);
    endtask

    task automatic do_reset();
        csb_i   = 1'b1;
        wen_i   = 1'b1;
        reset_i = 1'b0;
        @(negedge clk_i);
        @(negedge clk_i);
        reset_i = 1'b1;
        @(negedge clk_i);
    endtask

    // Checks one 8N1 frame, one sample per clock after each edge.
    task automatic expect_frame(input string name, input logic [7:0] b, input int len,
                                input bit chk_busy);
        logic [9:0]  f;
        logic [31:0] s;
        f = {1'b1, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            for (int c = 0; c < len; c++) begin
                @(negedge clk_i);
                check(name, 32'(tx_o), 32'(f[i]));
                if (chk_busy) begin
                    bus_read(A_ST, s);
                    check({name, "_busy"}, 32'(s[2]), 32'd1);
                end
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [9:0] f;
        int         bi;

        reset_i = 1'b0;
        csb_i   = 1'b1;
        wen_i   = 1'b1;
        addr_i  = '0;
        data_i  = '0;
        wmask_i = '0;

        vecs.push_back('{1'b0, A_ST,  32'h0,        4'b0000, 32'h002,  "rst_status"});
        vecs.push_back('{1'b0, A_DV,  32'h0,        4'b0000, 32'h364,  "rst_div"});
        vecs.push_back('{1'b0, A_CT,  32'h0,        4'b0000, 32'h0,    "rst_ctrl"});
        vecs.push_back('{1'b0, A_TX,  32'h0,        4'b0000, 32'h0,    "txdata_read"});
        vecs.push_back('{1'b1, A_DV,  32'h00001234, 4'b0001, 32'h334,  "div_byte0"});
        vecs.push_back('{1'b1, A_DV,  32'hABCD5678, 4'b0010, 32'h5634, "div_byte1"});
        vecs.push_back('{1'b1, A_DV,  32'hFFFF0004, 4'b1111, 32'h0004, "div_full"});
        vecs.push_back('{1'b0, 4'h9,  32'h0,        4'b0000, 32'h0004, "div_lowbits"});
        vecs.push_back('{1'b1, A_CT,  32'hFFFFFFFF, 4'b0001, CTRL_ALL, "ctrl_set"});
        vecs.push_back('{1'b1, A_CT,  32'h00000000, 4'b1110, CTRL_ALL, "ctrl_masked"});
        vecs.push_back('{1'b1, A_ST,  32'hFFFFFFFF, 4'b1111, 32'h002,  "status_ro"});
        vecs.push_back('{1'b0, 4'h6,  32'h0,        4'b0000, 32'h002,  "status_lowbits"});
        vecs.push_back('{1'b1, A_CT,  32'h0,        4'b0001, 32'h0,    "ctrl_clear"});

        @(negedge clk_i);
        @(negedge clk_i);
        reset_i = 1'b1;
        @(negedge clk_i);
        check("rst_tx", 32'(tx_o), 32'd1);
        check("rst_irq", 32'(irq_o), 32'd0);

        foreach (vecs[i]) begin
            if (vecs[i].wr) bus_write(vecs[i].addr, vecs[i].wdata, vecs[i].mask);
            read_check(vecs[i].name, vecs[i].addr, vecs[i].exp);
        end

        // data_o is zero when not selected or during a write cycle.
        addr_i = A_DV;
        #1;
        check("rdata_idle", data_o, 32'h0);
        @(negedge clk_i);
        csb_i   = 1'b0;
        wen_i   = 1'b0;
        wmask_i = 4'b0000;
        #1;
        check("rdata_write", data_o, 32'h0);
        @(negedge clk_i);
        csb_i = 1'b1;
        wen_i = 1'b1;

        // Overflow with TXEN=0, clear, then overflow while a pop happens.
        do_reset();
        bus_write(A_DV, 32'd1, 4'b0011);
        for (int i = 0; i < 9; i++) bus_write(A_TX, 32'h10 + 32'(i), 4'b0001);
        read_check("ovf_status", A_ST, 32'h089);
        bus_write(A_ST, 32'h8, 4'b0001);
        read_check("ovf_clear", A_ST, 32'h081);
        bus_write(A_CT, 32'h1, 4'b0001);
        bus_write(A_TX, 32'h55, 4'b0001);
        read_check("ovf_with_pop", A_ST, 32'h07C);

        // Single frame 0xA5 at DIV=4 plus interrupt timing.
        do_reset();
        bus_write(A_DV, 32'd4, 4'b0011);
        bus_write(A_CT, 32'h3, 4'b0001);
        bus_write(A_TX, 32'hA5, 4'b0001);
        check("a5_latency", 32'(tx_o), 32'd1);
        expect_frame("a5", 8'hA5, 4, 1'b0);
        check("irq_in_stop", 32'(irq_o), 32'd0);
        @(negedge clk_i);
        check("irq_after_stop", 32'(irq_o), IRQ_EXP);
        read_check("a5_done", A_ST, 32'h002);

        // Back-to-back frames.
        do_reset();
        bus_write(A_DV, 32'd2, 4'b0011);
        bus_write(A_TX, 32'h01, 4'b0001);
        bus_write(A_TX, 32'h80, 4'b0001);
        bus_write(A_CT, 32'h1, 4'b0001);
        expect_frame("b2b_0", 8'h01, 2, 1'b1);
        expect_frame("b2b_1", 8'h80, 2, 1'b1);
        @(negedge clk_i);
        read_check("b2b_done", A_ST, 32'h002);

        // DIV=0 gives one clock per bit.
        do_reset();
        bus_write(A_DV, 32'd0, 4'b0011);
        bus_write(A_CT, 32'h1, 4'b0001);
        bus_write(A_TX, 32'h3C, 4'b0001);
        expect_frame("div0", 8'h3C, 1, 1'b0);

        // DIV 4 -> 8 written during bit 3 applies from bit 4.
        bus_write(A_DV, 32'd4, 4'b0011);
        bus_write(A_TX, 32'h96, 4'b0001);
        f = {1'b1, 8'h96, 1'b0};
        for (int k = 1; k <= 64; k++) begin
            @(negedge clk_i);
            csb_i = 1'b1;
            wen_i = 1'b1;
            bi = (k <= 16) ? (k - 1) / 4 : 4 + (k - 17) / 8;
            check("div_change", 32'(tx_o), 32'(f[bi]));
            if (k == 13) begin
                csb_i   = 1'b0;
                wen_i   = 1'b0;
                addr_i  = A_DV;
                data_i  = 32'd8;
                wmask_i = 4'b0011;
            end
        end

        // Clearing TXEN mid-frame finishes the frame and stops popping.
        do_reset();
        bus_write(A_DV, 32'd1, 4'b0011);
        bus_write(A_TX, 32'h11, 4'b0001);
        bus_write(A_TX, 32'h22, 4'b0001);
        bus_write(A_CT, 32'h1, 4'b0001);
        bus_write(A_CT, 32'h0, 4'b0001);
        repeat (12) @(negedge clk_i);
        read_check("txen_off", A_ST, 32'h010);
        repeat (10) @(negedge clk_i);
        read_check("txen_off_hold", A_ST, 32'h010);

        // Reset during the data bits.
        do_reset();
        bus_write(A_DV, 32'd4, 4'b0011);
        bus_write(A_CT, 32'h1, 4'b0001);
        bus_write(A_TX, 32'h00, 4'b0001);
        repeat (10) @(negedge clk_i);
        check("mid_frame_tx", 32'(tx_o), 32'd0);
        reset_i = 1'b0;
        #1;
        check("async_rst_tx", 32'(tx_o), 32'd1);
        @(negedge clk_i);
        reset_i = 1'b1;
        @(negedge clk_i);
        check("post_rst_tx", 32'(tx_o), 32'd1);
        read_check("post_rst_div", A_DV, 32'h364);
        read_check("post_rst_status", A_ST, 32'h002);
        read_check("post_rst_ctrl", A_CT, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/uart_tx_periph.md
UART_TX_PERIPH -- requirements
Module: uart_tx_periph

Interface
REQ-001 The block SHALL have parameter FIFO_DEPTH, default 8, meaning TX FIFO entries (power of two, 2..16).
REQ-002 The block SHALL have parameter DEFAULT_DIV, default 16'd868, meaning the reset value of the baud divisor in clocks per bit.
REQ-003 Port clk_i, input, 1 bit: clock.
REQ-004 Port reset_i, input, 1 bit: reset, asynchronous, active-low.
REQ-005 Port csb_i, input, 1 bit: registered chip select, active-low.
REQ-006 Port wen_i, input, 1 bit: registered write enable, active-low.
REQ-007 Port addr_i, input, 4 bits: registered byte offset; bits [1:0] are ignored.
REQ-008 Port data_i, input, 32 bits: registered write data.
REQ-009 Port wmask_i, input, 4 bits: registered byte write mask.
REQ-010 Port data_o, output, 32 bits: read data.
REQ-011 Port tx_o, output, 1 bit: serial line, idle high.
REQ-012 Port irq_o, output, 1 bit: TX-empty interrupt.

Function
REQ-013 The register map SHALL be: 0x0 TXDATA (write-only, reads 0); 0x4 STATUS; 0x8 DIV[15:0]; 0xC CTRL (bit0 TXEN, bit1 IRQEN).
REQ-014 A write SHALL occur on the clk_i edge where csb_i=0 and wen_i=0, with only wmask_i-enabled bytes updated; a TXDATA push SHALL require wmask_i[0]=1.
REQ-015 data_o SHALL be a combinational function of addr_i when csb_i=0 and wen_i=1, and SHALL be 0 otherwise.
REQ-016 STATUS SHALL read bit0 full, bit1 empty, bit2 busy (FSM not IDLE), bit3 overflow (sticky), bits[8:4] FIFO count, other bits 0.
REQ-017 A TXDATA write while the FIFO is full SHALL be dropped and SHALL set overflow, even when a pop occurs in the same cycle.
REQ-018 Writing 1 to STATUS bit3 SHALL clear overflow; all other STATUS bits SHALL be read-only.
REQ-019 The FSM SHALL have states IDLE, START, DATA, STOP; the frame format SHALL be 8N1, LSB first.
REQ-020 In IDLE with TXEN=1 and the FIFO non-empty, the FSM SHALL pop one byte and enter START on the next edge, with tx_o registered low from that edge.
REQ-021 Each bit SHALL last max(DIV,1) clocks; START→DATA after one bit; DATA→STOP after 8 bits; STOP drives tx_o=1 for one bit and then returns to IDLE, or goes directly to START if the pop condition holds (back-to-back frames, no idle gap).
REQ-022 Latency SHALL be: TXDATA write at edge N into an empty FIFO with the FSM in IDLE produces a start bit beginning at edge N+1.
REQ-023 Clearing TXEN mid-frame SHALL let the current frame complete, after which no further pops occur.
REQ-024 A DIV write mid-frame SHALL take effect at the next bit boundary.
REQ-025 irq_o SHALL equal IRQEN & empty & ~busy.

Reset
REQ-026 On reset_i=0, the block SHALL asynchronously set: FSM IDLE; FIFO empty; overflow 0; DIV=DEFAULT_DIV; TXEN=0; IRQEN=0; tx_o=1; irq_o=0; bit and clock counters 0.
REQ-027 Reset asserted mid-frame SHALL abort the frame immediately, driving tx_o=1.

Configuration
REQ-028 Macro UART_TX_IRQ_EN defined: irq_o, IRQEN, and REQ-025 behave as specified.
REQ-029 Macro UART_TX_IRQ_EN undefined: irq_o SHALL be tied to 0, CTRL bit1 SHALL be unwritable and read 0, and no IRQ logic is compiled.

Structure
REQ-030 A shared package uart_tx_pkg SHALL hold the register offsets, the STATUS bit indices, the FSM state encoding, and the DEFAULT_DIV constant.
REQ-031 Sub-module uart_tx_fifo SHALL be a synchronous FIFO (push, pop, full, empty, count) with asynchronous active-low reset, instantiated once.

Verification
REQ-032 Directed test: DIV=4, TXEN=1, write 0xA5 to TXDATA → tx_o sequence 0,1,0,1,0,0,1,0,1,1, each level held 4 clocks, start bit at edge N+1.
REQ-033 Directed test: 9 TXDATA writes with TXEN=0 and FIFO_DEPTH=8 → STATUS=0x089 (count 8, full, overflow); write 0x8 to STATUS → STATUS=0x081.
REQ-034 Directed test: two bytes queued, TXEN=1 → second start bit immediately follows the first stop bit; busy=1 throughout; then STATUS empty=1 and busy=0.
REQ-035 Directed test: DIV=0 → each bit lasts 1 clock; DIV changed 4→8 during bit 3 → bit 4 onward lasts 8 clocks.
REQ-036 Directed test: reset_i pulsed low during DATA → tx_o=1 immediately; after release, DIV reads DEFAULT_DIV and STATUS=0x002.
REQ-037 Directed test: with UART_TX_IRQ_EN defined and IRQEN=1, irq_o rises the cycle after the last stop bit ends; without the macro, irq_o stays 0.
